decode_pipe: RTL and testbench
==============================

# decode_pipe

Registered, flow-controlled decode stage that replaces the purely combinational decoder between fetch and execute. It splits the instruction into its fields, generates the format-correct sign-extended immediate, and classifies the instruction format. A valid/ready handshake with a 2-entry skid buffer gives full throughput under backpressure, and a flush input discards in-flight instructions on redirects.

## Interface
- DWIDTH, 32, instruction/data/immediate width; must be ≥ 32
- AWIDTH, 32, program counter width
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid_i  input  1  fetch presents an instruction
- in_ready_o  output  1  stage can accept an instruction
- pc_i  input  AWIDTH  PC of the incoming instruction
- insn_i  input  DWIDTH  incoming instruction
- flush_i  input  1  discard all held and incoming instructions
- out_valid_o  output  1  decoded instruction available
- out_ready_i  input  1  execute accepts the decoded instruction
- pc_o, insn_o  output  AWIDTH, DWIDTH  PC and raw instruction, passed through
- opcode_o  output  7  insn[6:0]
- rd_o, rs1_o, rs2_o  output  5 each  insn[11:7], insn[19:15], insn[24:20]
- funct3_o, funct7_o  output  3, 7  insn[14:12], insn[31:25]
- shamt_o  output  5  insn[24:20]
- imm_o  output  DWIDTH  sign-extended immediate
- fmt_o  output  3  format code: R, I, S, B, U, J
- illegal_o  output  1  instruction not recognised

## Operation
- Format is selected by opcode:
  - I: OP-IMM, LOAD, JALR, SYSTEM
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC
  - J: JAL
  - R: OP, FENCE, and any other opcode
- Immediate per format, sign-extended from insn[31] to DWIDTH:
  - I: insn[31:20]
  - S: {insn[31:25], insn[11:7]}
  - B: {insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}
  - U: {insn[31:12], 12'b0}, then sign-extended
  - J: {insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}
  - R: 0
- Raw fields are always extracted unmasked, whatever the format.
- Storage is a main register (drives the outputs) and a skid register, each with a valid bit. Decode is computed on the input and stored decoded.
- Transfers:
  - Input accepted when in_valid_i && in_ready_o.
  - Output consumed when out_valid_o && out_ready_i.
- Accept into an empty main register, or one consumed this cycle: the entry goes to main.
- Accept while main is full and not consumed: the entry goes to skid.
- Consume while skid is valid: skid moves to main and skid empties.

## Timing
- Latency: 1 cycle from input accept to out_valid_o.
- Throughput: 1 instruction/cycle while out_ready_i is held high.
- in_ready_o = !skid_valid && !rst. It is driven from state only, with no combinational path from out_ready_i.
- While out_valid_o && !out_ready_i, all output fields stay stable.
- flush_i:
  - Both valid bits clear at the next edge.
  - Any input accepted in the same cycle is dropped.
  - flush_i has priority over accept and consume.
- Reset:
  - Every output register clears to 0 at the next edge, including out_valid_o, fmt_o (= R) and illegal_o.
  - in_ready_o is 0 while rst is high and 1 in the first cycle after.
  - Reset mid-transfer loses both entries.
- Both registers full: in_ready_o = 0. A consume in that cycle frees the skid register, so in_ready_o = 1 next cycle.

## Configuration
- DECODE_PIPE_ILLEGAL_CHK_EN defined:
  - illegal_o = 1 when insn[1:0] ≠ 2'b11 or the opcode is outside the RV32I opcode set.
  - An illegal instruction still flows through with fmt_o = R and imm_o = 0.
- Not defined: illegal_o is tied to 0 and no checking logic is generated.

## Structure
- Shared package (decode_pkg):
  - fmt_e enum: FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5.
  - A decoded-instruction struct, used for both the main and skid registers.
  - Opcode constants come from the existing constants header, extended with OP and FENCE.
- Sub-module imm_gen: combinational, (insn, fmt) → imm. Instantiated once, on the input side.

## Test plan
- addi x1,x2,-1 (0xFFF10093), out_ready_i = 1 → next cycle: out_valid_o = 1, rd_o = 1, rs1_o = 2, fmt_o = I, imm_o = 0xFFFFFFFF.
- sw x1,4(x2) (0x00112223) → fmt_o = S, imm_o = 0x4, rs2_o = 1, rs1_o = 2.
- jal x1,8 (0x008000EF) → fmt_o = J, imm_o = 0x8. lui x1,0x12345 (0x123450B7) → fmt_o = U, imm_o = 0x12345000.
- Stream of 4 instructions with out_ready_i = 0 from cycle 2:
  - in_ready_o falls after the second accept.
  - Outputs hold the first instruction.
  - Raising out_ready_i drains all 4 in order, with no loss or duplication.
- Skid buffer full, then flush_i = 1 with in_valid_i = 1 → next cycle: out_valid_o = 0, in_ready_o = 1, the flushed input is never output.
- With DECODE_PIPE_ILLEGAL_CHK_EN: insn 0x00000013 gives illegal_o = 0; insn 0x0000007F gives illegal_o = 1, fmt_o = R, imm_o = 0. Without the macro: illegal_o = 0 for both.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode types: instruction format codes, opcode constants, and the
// decoded-entry fields held in the main and skid registers.
package decode_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] shamt;
    fmt_e       fmt;
    logic       illegal;
  } dec_t;

  function automatic fmt_e fmt_of(input logic [6:0] opc);
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: return FMT_I;
      OPC_STORE:                                  return FMT_S;
      OPC_BRANCH:                                 return FMT_B;
      OPC_LUI, OPC_AUIPC:                         return FMT_U;
      OPC_JAL:                                    return FMT_J;
      default:                                    return FMT_R;
    endcase
  endfunction

  function automatic logic opc_legal(input logic [6:0] opc);
    return opc inside {OPC_LOAD, OPC_FENCE, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
                       OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM};
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: assembles the format's immediate bits
// and sign-extends from insn[31] to DWIDTH.
module imm_gen
  import decode_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [31:7]       ib,
  input  fmt_e              fmt,
  output logic [DWIDTH-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{ib[31]}}, ib[31:20]};
      FMT_S: imm32 = {{20{ib[31]}}, ib[31:25], ib[11:7]};
      FMT_B: imm32 = {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
      FMT_U: imm32 = {ib[31:12], 12'b0};
      FMT_J: imm32 = {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = DWIDTH'($signed(imm32));

endmodule

// File: rtl/decode_pipe.sv
// Registered decode stage with valid/ready handshake and a 2-entry skid buffer.
// Define DECODE_PIPE_ILLEGAL_CHK_EN to flag unrecognised opcodes on illegal_o.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [4:0]        shamt_o,
  output logic [DWIDTH-1:0] imm_o,
  output logic [2:0]        fmt_o,
  output logic              illegal_o
);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
    logic [DWIDTH-1:0] imm;
    dec_t              f;
  } entry_t;

  entry_t            dec_in, main_q, skid_q;
  logic              main_vld, skid_vld;
  logic [6:0]        opc;
  logic              ill_in;
  fmt_e              fmt_in;
  logic [DWIDTH-1:0] imm_in;
  logic              accept, consume;

  assign opc = insn_i[6:0];

`ifdef DECODE_PIPE_ILLEGAL_CHK_EN
  assign ill_in = (insn_i[1:0] != 2'b11) || !opc_legal(opc);
`else
  assign ill_in = 1'b0;
`endif

  // Illegal instructions still flow, but as R-format with a zero immediate
  assign fmt_in = ill_in ? FMT_R : fmt_of(opc);

  imm_gen #(.DWIDTH(DWIDTH)) u_imm (
    .ib  (insn_i[31:7]),
    .fmt (fmt_in),
    .imm (imm_in)
  );

  always_comb begin
    dec_in           = '0;
    dec_in.pc        = pc_i;
    dec_in.insn      = insn_i;
    dec_in.imm       = imm_in;
    dec_in.f.opcode  = opc;
    dec_in.f.rd      = insn_i[11:7];
    dec_in.f.rs1     = insn_i[19:15];
    dec_in.f.rs2     = insn_i[24:20];
    dec_in.f.funct3  = insn_i[14:12];
    dec_in.f.funct7  = insn_i[31:25];
    dec_in.f.shamt   = insn_i[24:20];
    dec_in.f.fmt     = fmt_in;
    dec_in.f.illegal = ill_in;
  end

  // Ready depends only on skid occupancy, never on out_ready_i
  assign in_ready_o = !skid_vld && !rst;
  assign accept     = in_valid_i && in_ready_o;
  assign consume    = main_vld && out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush_i) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (consume) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end else if (accept) begin
        main_q   <= dec_in;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      if (!main_vld) begin
        main_q   <= dec_in;
        main_vld <= 1'b1;
      end else begin
        skid_q   <= dec_in;
        skid_vld <= 1'b1;
      end
    end
  end

  assign out_valid_o = main_vld;
  assign pc_o        = main_q.pc;
  assign insn_o      = main_q.insn;
  assign imm_o       = main_q.imm;
  assign opcode_o    = main_q.f.opcode;
  assign rd_o        = main_q.f.rd;
  assign rs1_o       = main_q.f.rs1;
  assign rs2_o       = main_q.f.rs2;
  assign funct3_o    = main_q.f.funct3;
  assign funct7_o    = main_q.f.funct7;
  assign shamt_o     = main_q.f.shamt;
  assign fmt_o       = main_q.f.fmt;
  assign illegal_o   = main_q.f.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: directed steps plus a random stream,
// checked against a queue-based reference model of the decode stage.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
  logic [31:0] pc_i, insn_i, pc_o, insn_o, imm_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [4:0]  rd_o, rs1_o, rs2_o, shamt_o;
  logic [2:0]  funct3_o, fmt_o;
  logic        illegal_o;

  decode_pipe #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .insn_i(insn_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .funct3_o(funct3_o),
    .funct7_o(funct7_o), .shamt_o(shamt_o), .imm_o(imm_o), .fmt_o(fmt_o),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  logic [31:0] drained[$];
  logic [31:0] pc_ctr = 32'h1000;
  int          vectors = 0;
  int          miscompares = 0;

  `ifdef DECODE_PIPE_ILLEGAL_CHK_EN
  localparam bit CHK_EN = 1'b1;
  `else
  localparam bit CHK_EN = 1'b0;
  `endif

  function automatic exp_t ref_dec(input logic [31:0] pc, input logic [31:0] insn);
    exp_t e;
    int   v;
    logic known;
    e.pc   = pc;
    e.insn = insn;
    known  = insn[6:0] inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                               7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    e.ill  = CHK_EN && !(known && insn[1:0] == 2'b11);
    case (insn[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: e.fmt = 3'd1;
      7'h23:                      e.fmt = 3'd2;
      7'h63:                      e.fmt = 3'd3;
      7'h37, 7'h17:               e.fmt = 3'd4;
      7'h6F:                      e.fmt = 3'd5;
      default:                    e.fmt = 3'd0;
    endcase
    if (e.ill) e.fmt = 3'd0;
    // Immediates as signed sums: the top bit carries negative weight
    case (e.fmt)
      3'd1: v = insn[30:20] - (insn[31] ? 2048 : 0);
      3'd2: v = insn[30:25] * 32 + insn[11:7] - (insn[31] ? 2048 : 0);
      3'd3: v = insn[7] * 2048 + insn[30:25] * 32 + insn[11:8] * 2 - (insn[31] ? 4096 : 0);
      3'd4: v = insn[31:12] * 4096;
      3'd5: v = insn[19:12] * 4096 + insn[20] * 2048 + insn[30:21] * 2 - (insn[31] ? 1048576 : 0);
      default: v = 0;
    endcase
    e.imm = 32'(v);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_t e;
    chk("out_valid", 64'(out_valid_o), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready_o), 64'(q.size() < 2));
    if (q.size() > 0) begin
      e = q[0];
      chk("pc", 64'(pc_o), 64'(e.pc));
      chk("insn", 64'(insn_o), 64'(e.insn));
      chk("opcode", 64'(opcode_o), 64'(e.insn[6:0]));
      chk("rd", 64'(rd_o), 64'(e.insn[11:7]));
      chk("rs1", 64'(rs1_o), 64'(e.insn[19:15]));
      chk("rs2", 64'(rs2_o), 64'(e.insn[24:20]));
      chk("funct3", 64'(funct3_o), 64'(e.insn[14:12]));
      chk("funct7", 64'(funct7_o), 64'(e.insn[31:25]));
      chk("shamt", 64'(shamt_o), 64'(e.insn[24:20]));
      chk("imm", 64'(imm_o), 64'(e.imm));
      chk("fmt", 64'(fmt_o), 64'(e.fmt));
      chk("illegal", 64'(illegal_o), 64'(e.ill));
    end
  endtask

  // Called at a falling edge: drive, advance the model, clock, then check
  task automatic step(input logic v, input logic [31:0] insn, input logic rdy, input logic fl);
    logic acc, con;
    in_valid_i  = v;
    insn_i      = insn;
    pc_i        = pc_ctr;
    out_ready_i = rdy;
    flush_i     = fl;
    if (out_valid_o && rdy && !fl) drained.push_back(insn_o);
    if (fl) q.delete();
    else begin
      acc = v && (q.size() < 2);
      con = rdy && (q.size() > 0);
      if (con) void'(q.pop_front());
      if (acc) q.push_back(ref_dec(pc_ctr, insn));
    end
    pc_ctr += 4;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] r;
    logic [6:0]  opcs[11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                              7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    int k;
    r = $urandom();
    k = $urandom_range(0, 13);
    if (k < 11) r[6:0] = opcs[k];
    return r;
  endfunction

  initial begin
    logic [31:0] s[4];
    rst = 1'b1; in_valid_i = 1'b1; insn_i = 32'h00100093; pc_i = '0;
    out_ready_i = 1'b0; flush_i = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_fmt", 64'(fmt_o), 64'd0);
    chk("rst_imm", 64'(imm_o), 64'd0);
    chk("rst_illegal", 64'(illegal_o), 64'd0);
    chk("rst_insn", 64'(insn_o), 64'd0);
    rst = 1'b0; in_valid_i = 1'b0;
    #1 chk("rst_release_ready", 64'(in_ready_o), 64'd1);

    step(1'b1, 32'hFFF10093, 1'b1, 1'b0);
    chk("addi_valid", 64'(out_valid_o), 64'd1);
    chk("addi_rd", 64'(rd_o), 64'd1);
    chk("addi_rs1", 64'(rs1_o), 64'd2);
    chk("addi_fmt", 64'(fmt_o), 64'd1);
    chk("addi_imm", 64'(imm_o), 64'hFFFFFFFF);
    step(1'b1, 32'h00112223, 1'b1, 1'b0);
    chk("sw_fmt", 64'(fmt_o), 64'd2);
    chk("sw_imm", 64'(imm_o), 64'h4);
    chk("sw_rs2", 64'(rs2_o), 64'd1);
    chk("sw_rs1", 64'(rs1_o), 64'd2);
    step(1'b1, 32'h008000EF, 1'b1, 1'b0);
    chk("jal_fmt", 64'(fmt_o), 64'd5);
    chk("jal_imm", 64'(imm_o), 64'h8);
    step(1'b1, 32'h123450B7, 1'b1, 1'b0);
    chk("lui_fmt", 64'(fmt_o), 64'd4);
    chk("lui_imm", 64'(imm_o), 64'h12345000);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure stream of four
    s = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
    drained.delete();
    step(1'b1, s[0], 1'b1, 1'b0);
    step(1'b1, s[1], 1'b0, 1'b0);
    chk("stream_ready_fall", 64'(in_ready_o), 64'd0);
    chk("stream_hold0", 64'(insn_o), 64'(s[0]));
    step(1'b1, s[2], 1'b0, 1'b0);
    chk("stream_hold1", 64'(insn_o), 64'(s[0]));
    step(1'b1, s[2], 1'b1, 1'b0);
    step(1'b1, s[2], 1'b1, 1'b0);
    step(1'b1, s[3], 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stream_count", 64'(drained.size()), 64'd4);
    for (int i = 0; i < 4 && i < drained.size(); i++)
      chk("stream_order", 64'(drained[i]), 64'(s[i]));

    // Flush with both registers full and a valid input present
    step(1'b1, 32'h00600313, 1'b0, 1'b0);
    step(1'b1, 32'h00700393, 1'b0, 1'b0);
    chk("full_ready", 64'(in_ready_o), 64'd0);
    step(1'b1, 32'h00500293, 1'b0, 1'b1);
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_ready", 64'(in_ready_o), 64'd1);
    drained.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_no_output", 64'(drained.size()), 64'd0);

    // Illegal opcode handling
    step(1'b1, 32'h00000013, 1'b1, 1'b0);
    chk("legal_ill", 64'(illegal_o), 64'd0);
    step(1'b1, 32'h0000007F, 1'b1, 1'b0);
    chk("illegal_ill", 64'(illegal_o), 64'(CHK_EN));
    chk("illegal_fmt", 64'(fmt_o), 64'd0);
    chk("illegal_imm", 64'(imm_o), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset with both entries held
    step(1'b1, 32'h00800413, 1'b0, 1'b0);
    step(1'b1, 32'h00900493, 1'b0, 1'b0);
    rst = 1'b1; in_valid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    q.delete();
    chk("midrst_valid", 64'(out_valid_o), 64'd0);
    chk("midrst_ready", 64'(in_ready_o), 64'd0);
    rst = 1'b0;
    #1 chk("midrst_release", 64'(in_ready_o), 64'd1);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), rand_insn(),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
